pattern_pwm_capture: RTL and testbench

PATTERN_PWM_CAPTURE -- requirements
Module: pattern_pwm_capture

---
 rtl/pattern_pwm_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_pattern_pwm_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_pwm_capture.sv
// pattern_pwm_capture
//   Measures a burst of pulses produced by the pattern PWM generator: the
//   high time of the first pulse, the period between the first two rising
//   edges, the number of rising edges, and the slot pattern (one bit per
//   period-long slot, set when a rising edge fell inside that slot).
//   A burst ends after _IDLE_TIMEOUT clocks without a rising edge; valid
//   then pulses for one clock and all results hold until the next burst.
//
//   Optional build macro: PWM_CAP_GLITCH_FILTER_EN inserts a 3-sample
//   majority filter after the synchronizer (2 extra clocks of latency,
//   pulses of one clock or shorter are rejected).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cap_en       high arms the block, low aborts a capture in progress
//   pwm_in       asynchronous pulse train
//   meas_high    clocks the input was high during the first pulse
//   meas_period  clocks between the first and second rising edge (0 if none)
//   pulse_cnt    rising edges seen in the burst, saturating at 255
//   pat_out      recovered slot pattern, first slot in the LSB
//   busy         high from the first rising edge until the result is valid
//   valid        one-clock pulse when the results are final
//   overflow     sticky: some counter saturated during this burst
module pattern_pwm_capture #(
  parameter int _PAT_WIDTH    = 16,
  parameter int _CNT_WIDTH    = 16,
  parameter int _IDLE_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic                  pwm_in,
  output logic [_CNT_WIDTH-1:0] meas_high,
  output logic [_CNT_WIDTH-1:0] meas_period,
  output logic [7:0]            pulse_cnt,
  output logic [_PAT_WIDTH-1:0] pat_out,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow
);

  typedef logic [_CNT_WIDTH-1:0] cnt_t;
  typedef logic [_PAT_WIDTH-1:0] pat_t;

  localparam cnt_t CNT_MAX      = '1;
  localparam cnt_t TIMEOUT_LAST = cnt_t'(_IDLE_TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_FIRST = 3'd2;
  localparam logic [2:0] ST_TRACK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

  // True when incrementing v lands on (or stays at) all-ones.
  function automatic logic hits_max(input cnt_t v);
    return v >= (CNT_MAX - cnt_t'(1));
  endfunction

  logic       pwm_p0, pwm_p1;
  logic       sig, sig_d, rise;
  logic [2:0] state;
  logic       high_frozen;
  cnt_t       per_cnt, idle_cnt, slot_tmr, slot_idx;
  logic       slot_seen;

  // ---- stage p0/p1: two-flop synchronizer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p0 <= 1'b0;
      pwm_p1 <= 1'b0;
    end else begin
      pwm_p0 <= pwm_in;
      pwm_p1 <= pwm_p0;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic pwm_p2, pwm_p3, filt_p4;

  // ---- stage p2..p4: registered majority of three consecutive samples ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p2  <= 1'b0;
      pwm_p3  <= 1'b0;
      filt_p4 <= 1'b0;
    end else begin
      pwm_p2  <= pwm_p1;
      pwm_p3  <= pwm_p2;
      filt_p4 <= (pwm_p1 & pwm_p2) | (pwm_p1 & pwm_p3) | (pwm_p2 & pwm_p3);
    end
  end

  assign sig = filt_p4;
`else
  assign sig = pwm_p1;
`endif

  // ---- edge detection on the conditioned signal ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_d <= 1'b0;
    else        sig_d <= sig;
  end

  assign rise  = sig & ~sig_d;
  assign busy  = (state == ST_FIRST) || (state == ST_TRACK);
  assign valid = (state == ST_DONE);

  // ---- capture FSM and measurement registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      meas_high   <= '0;
      meas_period <= '0;
      pulse_cnt   <= '0;
      pat_out     <= '0;
      overflow    <= 1'b0;
      high_frozen <= 1'b0;
      per_cnt     <= '0;
      idle_cnt    <= '0;
      slot_tmr    <= '0;
      slot_idx    <= '0;
      slot_seen   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cap_en) state <= ST_ARMED;

        ST_ARMED: begin
          if (!cap_en) begin
            state <= ST_IDLE;
          end else if (rise) begin
            state       <= ST_FIRST;
            pulse_cnt   <= 8'd1;
            meas_high   <= cnt_t'(1);
            per_cnt     <= cnt_t'(1);
            meas_period <= '0;
            pat_out     <= pat_t'(1'b1);
            overflow    <= 1'b0;
            high_frozen <= 1'b0;
            idle_cnt    <= '0;
          end
        end

        ST_FIRST: begin
          if (!cap_en) begin
            state <= ST_IDLE;
          end else begin
            // High time stops at the first falling edge and never resumes.
            if (!high_frozen) begin
              if (sig) begin
                meas_high <= sat_inc(meas_high);
                if (hits_max(meas_high)) overflow <= 1'b1;
              end else begin
                high_frozen <= 1'b1;
              end
            end
            per_cnt <= sat_inc(per_cnt);
            if (hits_max(per_cnt)) overflow <= 1'b1;

            if (rise) begin
              // Second edge opens slot 1; slot 0 was the first pulse.
              state       <= ST_TRACK;
              meas_period <= per_cnt;
              pat_out     <= pat_t'(2'b11);
              pulse_cnt   <= 8'd2;
              idle_cnt    <= '0;
              slot_tmr    <= cnt_t'(1);
              slot_idx    <= cnt_t'(1);
              slot_seen   <= 1'b1;
            end else if (idle_cnt == TIMEOUT_LAST) begin
              state <= ST_DONE;
            end else begin
              idle_cnt <= sat_inc(idle_cnt);
            end
          end
        end

        ST_TRACK: begin
          if (!cap_en) begin
            state <= ST_IDLE;
          end else begin
            if (rise) begin
              if (pulse_cnt != 8'hFF) pulse_cnt <= pulse_cnt + 8'd1;
              if (pulse_cnt >= 8'hFE) overflow <= 1'b1;
              idle_cnt <= '0;
            end else if (idle_cnt == TIMEOUT_LAST) begin
              state <= ST_DONE;
            end else begin
              idle_cnt <= sat_inc(idle_cnt);
            end

            // slot_idx is the slot currently accumulating; it is written
            // when its period expires. An edge in the boundary clock is
            // credited to the slot that starts there.
            if (slot_tmr == meas_period) begin
              for (int i = 0; i < _PAT_WIDTH; i++) begin
                if (slot_idx == cnt_t'(i)) pat_out[i] <= slot_seen;
              end
              slot_idx <= sat_inc(slot_idx);
              if (hits_max(slot_idx)) overflow <= 1'b1;
              slot_seen <= rise;
              slot_tmr  <= cnt_t'(1);
            end else begin
              slot_tmr  <= slot_tmr + cnt_t'(1);
              slot_seen <= slot_seen | rise;
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_pwm_capture.sv
module tb_pattern_pwm_capture;

  localparam int PW   = 16;
  localparam int CW   = 16;
  localparam int TO   = 1024;
  localparam int MAXN = 4096;
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_en = 1'b0;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] meas_high, meas_period;
  logic [7:0]    pulse_cnt;
  logic [PW-1:0] pat_out;
  logic          busy, valid, overflow;

  pattern_pwm_capture #(
    ._PAT_WIDTH(PW), ._CNT_WIDTH(CW), ._IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .pwm_in(pwm_in),
    .meas_high(meas_high), .meas_period(meas_period), .pulse_cnt(pulse_cnt),
    .pat_out(pat_out), .busy(busy), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit wave[MAXN];
  bit sig_m[MAXN];
  bit exp_busy[MAXN];
  bit exp_valid[MAXN];
  int exp_valid_n;
  int e_high, e_period, e_cnt, e_pat, e_ovf;
  int cyc = 0;
  bit chk_en = 1'b0;
  int valid_seen, valid_cyc;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic bit wv(input int k);
    return (k < 0) ? 1'b0 : wave[k];
  endfunction

  // Conditioned input as seen by the edge detector, from the raw waveform.
  function automatic bit model_sig(input int j);
`ifdef PWM_CAP_GLITCH_FILTER_EN
    int s;
    s = int'(wv(j-3)) + int'(wv(j-4)) + int'(wv(j-5));
    return s >= 2;
`else
    return wv(j-2);
`endif
  endfunction

  task automatic clear_wave();
    for (int i = 0; i < MAXN; i++) wave[i] = 1'b0;
  endtask

  task automatic add_pulse(input int start, input int len);
    for (int i = start; i < start + len; i++) wave[i] = 1'b1;
  endtask

  // Derives every expected output from the list of rising-edge times.
  task automatic build_model(input int n, input int abort_at);
    int r[$];
    int last, used, d, p, lo, hi, j;
    for (int i = 0; i < MAXN; i++) begin
      exp_busy[i] = 1'b0; exp_valid[i] = 1'b0; sig_m[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) sig_m[i] = model_sig(i);
    for (int i = 1; i < n; i++) if (sig_m[i] && !sig_m[i-1]) r.push_back(i);
    exp_valid_n = 0; e_high = 0; e_period = 0; e_cnt = 0; e_pat = 0; e_ovf = 0;
    if (r.size() == 0) return;
    last = r[0]; used = 1;
    for (int k = 1; k < r.size(); k++) begin
      if (r[k] - last > TO) break;
      last = r[k]; used++;
    end
    d = last + TO;
    j = r[0];
    while (j < n && sig_m[j]) j++;
    e_high = j - r[0];
    p = (used >= 2) ? r[1] - r[0] : 0;
    if (abort_at >= 0 && abort_at <= d) begin
      int cnt_before;
      cnt_before = 0;
      for (int k = 0; k < used; k++) if (r[k] < abort_at) cnt_before++;
      used = cnt_before;
      for (int i = r[0] + 1; i <= abort_at; i++) exp_busy[i] = 1'b1;
    end else if (d + 1 >= n) begin
      checks++; errors++;
      $display("FAIL model window: burst end %0d beyond stimulus length %0d", d + 1, n);
    end else begin
      for (int i = r[0] + 1; i <= d; i++) exp_busy[i] = 1'b1;
      exp_valid[d+1] = 1'b1;
      exp_valid_n = 1;
    end
    e_cnt = (used > 255) ? 255 : used;
    e_ovf = (used >= 255) ? 1 : 0;
    e_period = p;
    e_pat = 1;
    if (used >= 2) begin
      e_pat = e_pat | 2;
      for (int k = 2; k < PW; k++) begin
        lo = r[1] + (k - 1) * p;
        hi = lo + p;
        if (hi <= d)
          for (int m = 0; m < used; m++)
            if (r[m] >= lo && r[m] < hi) e_pat = e_pat | (1 << k);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy[cyc]);
      check("valid", valid, exp_valid[cyc]);
      if (valid) begin valid_seen++; valid_cyc = cyc; end
      if (exp_valid[cyc]) begin
        check("meas_high", meas_high, e_high);
        check("meas_period", meas_period, e_period);
        check("pulse_cnt", pulse_cnt, e_cnt);
        check("pat_out", pat_out, e_pat);
        check("overflow", overflow, e_ovf);
      end
    end
  end

  task automatic run_burst(input string tag, input int n, input int abort_at);
    build_model(n, abort_at);
    @(posedge clk); #1 cap_en = 1'b0; pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 cap_en = 1'b1;
    repeat (2) @(posedge clk);
    valid_seen = 0; valid_cyc = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pwm_in = wave[i]; cyc = i; chk_en = 1'b1;
      if (i == abort_at) cap_en = 1'b0;
    end
    @(posedge clk); #1 chk_en = 1'b0; pwm_in = 1'b0;
    check({tag, " valid count"}, valid_seen, exp_valid_n);
    if (abort_at < 0) begin
      check({tag, " hold meas_high"}, meas_high, e_high);
      check({tag, " hold meas_period"}, meas_period, e_period);
      check({tag, " hold pulse_cnt"}, pulse_cnt, e_cnt);
      check({tag, " hold pat_out"}, pat_out, e_pat);
    end
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("reset busy", busy, 0);
    check("reset valid", valid, 0);
    check("reset pulse_cnt", pulse_cnt, 0);
    check("reset pat_out", pat_out, 0);
    check("reset meas_high", meas_high, 0);
    check("reset overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Two pulses, high 2, period 16
    clear_wave(); add_pulse(4, 2); add_pulse(20, 2);
    run_burst("two_pulse", 20 + TO + 30, -1);
    check("two_pulse high lit", meas_high, 2);
    check("two_pulse period lit", meas_period, 16);
    check("two_pulse cnt lit", pulse_cnt, 2);
    check("two_pulse pat lit", pat_out, 16'h0003);

    // Period 21, slots 1,1,0,1 (last edge exactly on a slot boundary)
    clear_wave(); add_pulse(4, 2); add_pulse(25, 2); add_pulse(67, 2);
    run_burst("slots_1101", 67 + TO + 30, -1);
    check("slots_1101 cnt lit", pulse_cnt, 3);
    check("slots_1101 pat lit", pat_out, 16'h000B);
    check("slots_1101 period lit", meas_period, 21);

    // Edge in the last clock of slot 2
    clear_wave(); add_pulse(4, 2); add_pulse(14, 2); add_pulse(33, 2);
    run_burst("slot_end", 33 + TO + 30, -1);
    check("slot_end pat lit", pat_out, 16'h0007);

    // Single 5-clock pulse
    clear_wave(); add_pulse(4, 5);
    run_burst("single", 4 + TO + 30, -1);
    check("single high lit", meas_high, 5);
    check("single period lit", meas_period, 0);
    check("single cnt lit", pulse_cnt, 1);
    check("single pat lit", pat_out, 16'h0001);
    check("single valid time", valid_cyc, 4 + LAT + TO + 1);

    // Edge gap exactly equal to the timeout keeps the burst alive
    clear_wave(); add_pulse(4, 2); add_pulse(4 + TO, 2);
    run_burst("gap_eq_timeout", 4 + 2 * TO + 30, -1);
    check("gap_eq_timeout cnt lit", pulse_cnt, 2);
    check("gap_eq_timeout period lit", meas_period, TO);

    // 300 pulses, period 5: pulse count saturates
    clear_wave();
    for (int k = 0; k < 300; k++) add_pulse(4 + 5 * k, 2);
    run_burst("sat", 4 + 1500 + TO + 30, -1);
    check("sat cnt lit", pulse_cnt, 255);
    check("sat overflow lit", overflow, 1);
    check("sat pat lit", pat_out, 16'hFFFF);

    // One-clock glitch ahead of a normal burst
    clear_wave(); add_pulse(4, 1); add_pulse(10, 2); add_pulse(26, 2);
    run_burst("glitch", 26 + TO + 30, -1);
`ifdef PWM_CAP_GLITCH_FILTER_EN
    check("glitch high lit", meas_high, 2);
    check("glitch period lit", meas_period, 16);
    check("glitch cnt lit", pulse_cnt, 2);
    check("glitch pat lit", pat_out, 16'h0003);
`else
    check("glitch high lit", meas_high, 1);
    check("glitch cnt lit", pulse_cnt, 3);
`endif

    // cap_en dropped while tracking
    clear_wave();
    for (int k = 0; k < 6; k++) add_pulse(4 + 16 * k, 2);
    run_burst("abort", 60 + TO + 30, 60);
    check("abort busy", busy, 0);
    check("abort cnt held", pulse_cnt, 4);

    // Reset asserted mid-burst
    clear_wave(); add_pulse(4, 2); add_pulse(20, 2);
    @(posedge clk); #1 cap_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 cap_en = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 pwm_in = wave[i];
    end
    #2 check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset pulse_cnt", pulse_cnt, 0);
    check("mid reset meas_high", meas_high, 0);
    check("mid reset meas_period", meas_period, 0);
    check("mid reset pat_out", pat_out, 0);
    check("mid reset overflow", overflow, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    begin
      bit active;
      active = 1'b0;
      for (int i = 0; i < TO + 40; i++) begin
        @(negedge clk);
        if (valid || busy) active = 1'b1;
      end
      check("no burst after reset", active, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
